// File: rtl/sr_pkg.sv
// Shared definitions for the clocked set/reset storage bank.
// Holds the encodings of the MODE parameter, which selects how a cell
// resolves the s=r=1 input combination.
package sr_pkg;

  localparam int SR_MODE_SET_DOM = 0;
  localparam int SR_MODE_RST_DOM = 1;
  localparam int SR_MODE_HOLD    = 2;
  localparam int SR_MODE_TOGGLE  = 3;

endpackage

// File: rtl/sr_cell.sv
// One-bit clocked set/reset storage cell with a sticky conflict flag.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   rst_val       - value q takes on reset
//   en            - sample enable; low means q and the flag hold
//   s, r          - set / reset requests
//   conflict_clr  - clears the conflict flag (a new conflict still wins)
//   q             - stored value
//   conflict      - set when s=r=1 is sampled with en high
module sr_cell
  import sr_pkg::*;
#(
  parameter int MODE = SR_MODE_SET_DOM
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic conflict_clr,
  output logic q,
  output logic conflict
);

  logic q_q, q_d;
  logic conflict_q, conflict_d;

  // Next-state decode; the clear is applied first so that a conflict
  // sampled in the same cycle overrides it.
  always_comb begin
    q_d        = q_q;
    conflict_d = conflict_q;
    if (conflict_clr) begin
      conflict_d = 1'b0;
    end
    if (en) begin
      unique case ({s, r})
        2'b10: q_d = 1'b1;
        2'b01: q_d = 1'b0;
        2'b11: begin
          conflict_d = 1'b1;
          // Any MODE outside the defined set falls back to hold.
          case (MODE)
            SR_MODE_SET_DOM: q_d = 1'b1;
            SR_MODE_RST_DOM: q_d = 1'b0;
            SR_MODE_TOGGLE:  q_d = ~q_q;
            default:         q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
  end

  // Reset overrides any pending set, reset or toggle in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q        <= rst_val;
      conflict_q <= 1'b0;
    end else begin
      q_q        <= q_d;
      conflict_q <= conflict_d;
    end
  end

  assign q        = q_q;
  assign conflict = conflict_q;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of WIDTH synchronous set/reset cells replacing a cross-coupled RS
// latch, with per-channel sticky conflict flags and a shared saturating
// count of cycles in which any channel saw s=r=1.
// Ports:
//   clk, rst      - rising-edge clock, synchronous active-high reset
//   en            - sample enable for all channels and the counter
//   s, r          - per-channel set / reset requests
//   conflict_clr  - clears flags and counter (new conflicts still win)
//   q, q_n        - stored value and its exact complement
//   conflict      - sticky per-channel conflict flags
//   conflict_cnt  - saturating count of conflict cycles
module sr_latch_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               MODE    = SR_MODE_SET_DOM,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             conflict_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             any_conflict;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE(MODE)
    ) u_cell (
      .clk         (clk),
      .rst         (rst),
      .rst_val     (RST_VAL[i]),
      .en          (en),
      .s           (s[i]),
      .r           (r[i]),
      .conflict_clr(conflict_clr),
      .q           (q[i]),
      .conflict    (conflict[i])
    );
  end

  // One count per cycle regardless of how many channels collide.
  assign any_conflict = en && (|(s & r));

  // Clear first, then a same-cycle conflict restarts the count at 1.
  always_comb begin
    cnt_d = cnt_q;
    if (conflict_clr) begin
      cnt_d = '0;
    end
    if (any_conflict && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // q is registered, so its inverse is glitch-free and never equals q.
  assign q_n          = ~q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Directed bench for sr_latch_bank. Five copies share one set of inputs:
// MODE 0..3 with a 3-bit counter, and an illegal MODE 5 with an 8-bit
// counter, all with RST_VAL=8'hA5. Expected values are hand-derived.
module tb_sr_latch_bank;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [7:0] s = '0;
  logic [7:0] r = '0;
  logic       conflict_clr = 1'b0;

  logic [7:0] q_o    [NI];
  logic [7:0] qn_o   [NI];
  logic [7:0] conf_o [NI];
  logic [7:0] cnt_o  [NI];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  localparam int MODE_TAB [NI] = '{0, 1, 2, 3, 5};

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = (g < 4) ? 3 : 8;
    logic [CW-1:0] cnt_w;
    sr_latch_bank #(
      .WIDTH  (8),
      .MODE   (MODE_TAB[g]),
      .RST_VAL(8'hA5),
      .CNT_W  (CW)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .s           (s),
      .r           (r),
      .conflict_clr(conflict_clr),
      .q           (q_o[g]),
      .q_n         (qn_o[g]),
      .conflict    (conf_o[g]),
      .conflict_cnt(cnt_w)
    );
    assign cnt_o[g] = 8'(cnt_w);
  end

  // Drive one cycle of inputs and sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst_v, input logic en_v,
                               input logic clr_v, input logic [7:0] s_v,
                               input logic [7:0] r_v);
    rst = rst_v;
    en = en_v;
    conflict_clr = clr_v;
    s = s_v;
    r = r_v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkValue(input string tag, input int idx,
                            input logic [7:0] obs, input logic [7:0] exp_v);
    tests++;
    assert (obs === exp_v)
    else begin
      fails++;
      $error("[TB] FAIL %s inst%0d: observed %h expected %h", tag, idx, obs, exp_v);
    end
  endtask

  // Check every output of every instance; counts differ per instance.
  task automatic checkOutput(input string tag, input logic [7:0] exp_q [NI],
                             input logic [7:0] exp_conf,
                             input logic [7:0] exp_cnt [NI]);
    for (int i = 0; i < NI; i++) begin
      checkValue({tag, ".q"}, i, q_o[i], exp_q[i]);
      checkValue({tag, ".q_n"}, i, qn_o[i], ~exp_q[i]);
      checkValue({tag, ".conflict"}, i, conf_o[i], exp_conf);
      checkValue({tag, ".cnt"}, i, cnt_o[i], exp_cnt[i]);
    end
  endtask

  initial begin
    logic [7:0] eq [NI];
    logic [7:0] ec [NI];

    // Reset loads RST_VAL and clears flags and counter.
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    eq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    ec = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    checkOutput("reset", eq, 8'h00, ec);

    // Channel 0: reset, set, hold, reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
    eq = '{8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4};
    checkOutput("ch0_rst", eq, 8'h00, ec);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    eq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    checkOutput("ch0_set", eq, 8'h00, ec);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    checkOutput("ch0_hold", eq, 8'h00, ec);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h01);
    eq = '{8'hA4, 8'hA4, 8'hA4, 8'hA4, 8'hA4};
    checkOutput("ch0_rst2", eq, 8'h00, ec);

    // s=r=1 on channel 3 with q[3]=0, twice.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h08, 8'h08);
    eq = '{8'hAC, 8'hA4, 8'hA4, 8'hAC, 8'hA4};
    ec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    checkOutput("ch3_conf1", eq, 8'h08, ec);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h08, 8'h08);
    eq = '{8'hAC, 8'hA4, 8'hA4, 8'hA4, 8'hA4};
    ec = '{8'd2, 8'd2, 8'd2, 8'd2, 8'd2};
    checkOutput("ch3_conf2", eq, 8'h08, ec);

    // Enable low: everything holds, no conflicts logged.
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
      checkOutput("en_low", eq, 8'h08, ec);
    end

    // Ten conflict cycles on channel 1: 3-bit counters stop at 7.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h02, 8'h02);
      eq = '{8'hAE, 8'hA4, 8'hA4, (k % 2 == 1) ? 8'hA6 : 8'hA4, 8'hA4};
      for (int i = 0; i < 4; i++) ec[i] = (2 + k > 7) ? 8'd7 : 8'(2 + k);
      ec[4] = 8'(2 + k);
      checkOutput("saturate", eq, 8'h0A, ec);
    end

    // Clear plus a new conflict on channel 1: the new event wins.
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h02, 8'h02);
    eq = '{8'hAE, 8'hA4, 8'hA4, 8'hA6, 8'hA4};
    ec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    checkOutput("clr_and_conf", eq, 8'h02, ec);

    // Clear still acts while enable is low.
    applyStimulus(1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    ec = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    checkOutput("clr_en_low", eq, 8'h00, ec);

    // Reset in the same cycle as a toggle request wins.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
    eq = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    checkOutput("rst_mid_toggle", eq, 8'h00, ec);

    // Conflict on channel 0 (q[0]=1) after reset.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
    eq = '{8'hA5, 8'hA4, 8'hA5, 8'hA4, 8'hA5};
    ec = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    checkOutput("ch0_conf", eq, 8'h01, ec);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
